// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared engine states, access size codes and request-slot layout for mem_responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } slot_t;
endpackage

// File: rtl/mem_resp_sram.sv
// mem_resp_sram: word array with byte-masked write and a registered read port (read data resets, array does not)
module mem_resp_sram #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic          zero,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  output logic [31:0]   rdata
);
  logic [31:0] mem [WORDS];
  always_ff @(posedge clock)
    if (en && we)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clock or posedge reset)
    if (reset) rdata <= '0;
    else if (en) rdata <= zero ? '0 : mem[idx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: two-port (IFU/LSU) fixed-latency memory responder; MEM_RESP_ERR_EN adds a sticky err flag
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic        io_ifu_respValid,
  output logic [31:0] io_ifu_rdata,
  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic [1:0]  io_lsu_size,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  output logic        io_lsu_respValid,
  output logic [31:0] io_lsu_rdata
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        err
`endif
);
  localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] LAT1 = 4'(LATENCY - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic sel, sel_n, start, fault, ifu_take, lsu_take, ifu_pend, lsu_pend, in_resp;
  slot_t ifu_slot, lsu_slot, cur;
  logic [31:0] word, sram_rdata, ifu_hold, lsu_hold;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    start   = 1'b0;
    if (state == IDLE && (ifu_pend || lsu_pend)) begin
      sel_n   = lsu_pend;
      cnt_n   = LAT1;
      state_n = (LATENCY == 1) ? RESP : WAIT;
      start   = (LATENCY == 1);
    end else if (state == WAIT) begin
      cnt_n   = cnt - 4'd1;
      state_n = (cnt == 4'd1) ? RESP : WAIT;
      start   = (cnt == 4'd1);
    end else if (state == RESP) begin
      state_n = IDLE;
    end
  end
  // sel_n is the slot about to be served: sel in WAIT, the arbitration winner in IDLE
  assign cur      = sel_n ? lsu_slot : ifu_slot;
  assign word     = {2'b00, cur.addr[31:2]};
  assign in_resp  = state == RESP;
  assign ifu_take = io_ifu_reqValid && (!ifu_pend || (in_resp && !sel));
  assign lsu_take = io_lsu_reqValid && (!lsu_pend || (in_resp && sel));
`ifdef MEM_RESP_ERR_EN
  assign fault = word >= 32'(MEM_WORDS) || (sel_n ?
    ((cur.size == SIZE_H && cur.addr[0]) || (cur.size == SIZE_W && cur.addr[1:0] != 2'b00)) :
    cur.addr[1:0] != 2'b00);
  always_ff @(posedge clock or posedge reset)
    if (reset) err <= 1'b0;
    else if (start && fault) err <= 1'b1;
`else
  logic unused;
  assign fault  = 1'b0;
  assign unused = ^{cur.addr[1:0], cur.size};
`endif
  mem_resp_sram #(.WORDS(MEM_WORDS), .AW(AW)) u_sram (
    .clock(clock),
    .reset(reset),
    .en(start),
    .we(sel_n && cur.wen && !fault),
    .zero(fault),
    .idx(AW'(word % 32'(MEM_WORDS))),
    .wdata(cur.wdata),
    .wmask(cur.wmask),
    .rdata(sram_rdata)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sel      <= 1'b0;
      ifu_pend <= 1'b0;
      lsu_pend <= 1'b0;
      ifu_slot <= '0;
      lsu_slot <= '0;
      ifu_hold <= '0;
      lsu_hold <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sel      <= sel_n;
      ifu_pend <= ifu_take || (ifu_pend && !(in_resp && !sel));
      lsu_pend <= lsu_take || (lsu_pend && !(in_resp && sel));
      if (ifu_take) ifu_slot <= '{addr: io_ifu_addr, size: SIZE_W, wen: 1'b0, wdata: '0, wmask: '0};
      if (lsu_take) lsu_slot <= '{addr: io_lsu_addr, size: io_lsu_size, wen: io_lsu_wen,
                                  wdata: io_lsu_wdata, wmask: io_lsu_wmask};
      if (in_resp && sel) lsu_hold <= sram_rdata;
      if (in_resp && !sel) ifu_hold <= sram_rdata;
    end
  end
  assign io_ifu_respValid = in_resp && !sel;
  assign io_lsu_respValid = in_resp && sel;
  assign io_ifu_rdata     = io_ifu_respValid ? sram_rdata : ifu_hold;
  assign io_lsu_rdata     = io_lsu_respValid ? sram_rdata : lsu_hold;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 4096, number of 32-bit words in the internal array.
REQ-002 Parameter LATENCY, default 2, cycles from request sample edge to respValid; legal range 1..15.
REQ-003 Ports `clock` in 1, the single clock; `reset` in 1, asynchronous, active-high.
REQ-004 Ports io_ifu_reqValid in 1 (fetch request); io_ifu_addr in 32 (byte address); io_ifu_respValid out 1 (one-cycle response pulse); io_ifu_rdata out 32 (aligned word read).
REQ-005 Ports io_lsu_reqValid in 1 (data request); io_lsu_addr in 32 (byte address); io_lsu_size in 2 (0 byte, 1 half, 2 word); io_lsu_wen in 1 (1 = write); io_lsu_wdata in 32 (write data, byte lanes already positioned); io_lsu_wmask in 4 (byte enables); io_lsu_respValid out 1 (one-cycle response pulse); io_lsu_rdata out 32 (aligned word read).
REQ-006 Port err out 1, sticky error flag; present only with MEM_RESP_ERR_EN.

Function
REQ-007 Each port SHALL hold a pending slot; a cycle with reqValid high SHALL capture that port's addr/size/wen/wdata/wmask into the slot and set pending, whether or not the engine is busy.
REQ-008 reqValid asserted while the same port's slot is already pending SHALL be ignored (no overwrite); a level-held reqValid counts as one request.
REQ-009 Engine states IDLE, WAIT, RESP; IDLE->WAIT when any slot pending, selecting LSU over IFU when both pending; WAIT counts down from LATENCY-1; at zero ->RESP; RESP->IDLE unconditionally.
REQ-010 With LATENCY=1, WAIT SHALL last zero cycles (IDLE->RESP directly).
REQ-011 A request captured at edge N SHALL see its respValid high for exactly the cycle following edge N+LATENCY when the engine was idle and no other slot pending.
REQ-012 Array access SHALL occur on the edge entering RESP: read word index addr[31:2] modulo MEM_WORDS into a registered rdata; for LSU writes, update only bytes with wmask bit set.
REQ-013 Write responses SHALL pulse io_lsu_respValid; io_lsu_rdata then returns the pre-write word.
REQ-014 rdata outputs SHALL hold their last value until the next response on the same port.
REQ-015 The served slot's pending bit SHALL clear on the edge leaving RESP; a new reqValid on that port in the RESP cycle SHALL be captured as a fresh request.
REQ-016 io_ifu_respValid and io_lsu_respValid SHALL never be high in the same cycle; at most one response in flight.
REQ-017 addr[1:0] and size SHALL NOT alter data path; requester extracts sub-word data.

Reset
REQ-018 Reset SHALL force state IDLE, counter 0, both pending 0, both respValid 0, both rdata 0, err 0; array contents are not reset.
REQ-019 Reset asserted mid-transaction SHALL abandon it without array write and without respValid.

Configuration
REQ-020 With MEM_RESP_ERR_EN defined, err SHALL set (sticky until reset) on the RESP edge when word index >= MEM_WORDS or access is misaligned (size 1 with addr[0]=1, size 2 with addr[1:0]!=0, IFU with addr[1:0]!=0); a faulting write SHALL be suppressed and faulting reads SHALL return 0; respValid timing unchanged.
REQ-021 Without MEM_RESP_ERR_EN, no err port; addresses wrap modulo MEM_WORDS and misalignment is ignored.

Structure
REQ-022 Shared package mem_resp_pkg SHALL hold the state enum (IDLE/WAIT/RESP), size encodings (SIZE_B/H/W) and request-slot struct.
REQ-023 One sub-module mem_resp_sram (word array, byte-masked write, registered read) SHALL be instantiated; arbitration and FSM live in mem_responder.

Verification
REQ-024 LATENCY=2, preload word 0x10 = 0x12345678; IFU reqValid pulse addr 0x40 at edge 5 -> io_ifu_respValid high only in cycle after edge 7, io_ifu_rdata=0x12345678.
REQ-025 LSU write addr 0x80 wdata 0xAABBCCDD wmask 0b0101 over 0x11111111, then LSU read 0x80 -> rdata 0x11BB11DD.
REQ-026 IFU and LSU reqValid same cycle -> LSU response first, IFU response LATENCY+1 cycles later, never overlapping.
REQ-027 LSU reqValid held high 10 cycles -> exactly one response if held only through RESP cycle... held past RESP -> second response captured and served.
REQ-028 Reset asserted during WAIT of write to 0x100 -> no respValid, word 0x100 unchanged, all outputs 0.
REQ-029 MEM_RESP_ERR_EN, MEM_WORDS=4096: LSU word read at 0x4000 -> rdata 0, err=1 persisting; half read at 0x3 -> err=1.
